// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the single-cycle control decoder.
// Holds the PC, runs a request/ready handshake with instruction memory, keeps
// the fetched word stable while it executes, and selects the next PC from
// the decoder's branch/jump controls.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When defined, a redirect to
// a target with nonzero low bits parks the unit in FAULT until reset. When
// undefined, the low two target bits are cleared and fetch continues.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        is_jump,
    input  logic        zero_branch,
    input  logic        need_zero,
    input  logic        alu_zero,
    input  logic        status_branch,
    input  logic        need_st_Z,
    input  logic        st_Z,
    input  logic [1:0]  pc_select,
    input  logic [31:0] reg_target,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT = 2'b11
`endif
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic        valid_r;
    logic        valid_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] branch_off_s;
    logic        taken_s;
    logic [31:0] target_s;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_r;
    logic        fault_s;
`endif

    assign pc_plus4_s   = pc_r + 32'd4;
    assign branch_off_s = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};

    // The OR covers every priority case: any jump/branch source that fires
    // takes the same pc_select-chosen target, so is_jump simply wins.
    assign taken_s = is_jump
                   | (zero_branch   & (alu_zero == need_zero))
                   | (status_branch & (st_Z     == need_st_Z));

    // Redirect target, unaligned; alignment policy is applied at the HOLD exit.
    always_comb begin
        target_s = pc_plus4_s;
        if (taken_s) begin
            case (pc_select)
                2'b00:   target_s = pc_plus4_s;
                2'b01:   target_s = pc_plus4_s + branch_off_s;
                2'b10:   target_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
                2'b11:   target_s = reg_target;
                default: target_s = pc_plus4_s;
            endcase
        end else begin
            target_s = pc_plus4_s;
        end
    end

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        valid_s = valid_r;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_s = fault_r;
`endif
        case (state_r)
            IDLE: begin
                state_s = FETCH;
                instr_s = NOP_WORD;
                valid_s = 1'b0;
            end
            FETCH: begin
                // advance is deliberately not looked at here
                if (imem_ready) begin
                    instr_s = imem_rdata;
                    valid_s = 1'b1;
                    state_s = HOLD;
                end else begin
                    instr_s = NOP_WORD;
                    valid_s = 1'b0;
                    state_s = FETCH;
                end
            end
            HOLD: begin
                if (advance) begin
                    instr_s = NOP_WORD;
                    valid_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (target_s[1:0] != 2'b00) begin
                        // pc keeps the faulting instruction's address
                        state_s = FAULT;
                        fault_s = 1'b1;
                    end else begin
                        pc_s    = target_s;
                        state_s = FETCH;
                    end
`else
                    pc_s    = target_s & 32'hFFFF_FFFC;
                    state_s = FETCH;
`endif
                end else begin
                    state_s = HOLD;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
                state_s = FAULT;
                fault_s = 1'b1;
                valid_s = 1'b0;
                instr_s = NOP_WORD;
            end
`endif
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                instr_s = NOP_WORD;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            valid_r <= valid_s;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_r <= fault_s;
`endif
        end
    end

    assign imem_req    = (state_r == FETCH);
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign instruction = instr_r;
    assign instr_valid = valid_r;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fault       = fault_r;
`else
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with hand-computed
// expected fetch addresses and instruction words.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        is_jump;
    logic        zero_branch;
    logic        need_zero;
    logic        alu_zero;
    logic        status_branch;
    logic        need_st_Z;
    logic        st_Z;
    logic [1:0]  pc_select;
    logic [31:0] reg_target;
    logic        fault;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .advance       (advance),
        .is_jump       (is_jump),
        .zero_branch   (zero_branch),
        .need_zero     (need_zero),
        .alu_zero      (alu_zero),
        .status_branch (status_branch),
        .need_st_Z     (need_st_Z),
        .st_Z          (st_Z),
        .pc_select     (pc_select),
        .reg_target    (reg_target),
        .fault         (fault)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request at exp_addr, answer it with rdata.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata);
        logic [31:0] exp_p4;
        int n;
        exp_p4 = exp_addr + 32'd4;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
        check_eq("fetch_addr", imem_addr, exp_addr);
        check_eq("fetch_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("fetch_nop", instruction, NOP);
        imem_ready = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("hold_instr", instruction, rdata);
        check_eq("hold_req", {31'd0, imem_req}, 32'd0);
        check_eq("hold_pc", pc, exp_addr);
        check_eq("hold_pc4", pc_plus4, exp_p4);
    endtask

    // One advance edge with the given decoder controls.
    task automatic do_adv(input logic j, input logic zb, input logic nz, input logic az,
                          input logic sb, input logic nsz, input logic sz,
                          input logic [1:0] sel, input logic [31:0] tgt);
        is_jump = j; zero_branch = zb; need_zero = nz; alu_zero = az;
        status_branch = sb; need_st_Z = nsz; st_Z = sz;
        pc_select = sel; reg_target = tgt;
        advance = 1'b1;
        step();
        advance = 1'b0; is_jump = 1'b0; zero_branch = 1'b0; need_zero = 1'b0;
        alu_zero = 1'b0; status_branch = 1'b0; need_st_Z = 1'b0; st_Z = 1'b0;
        pc_select = 2'b00; reg_target = 32'h0000_0000;
        check_eq("adv_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic do_jump(input logic [31:0] tgt);
        do_adv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, tgt);
    endtask

    // Directed stimulus sequence.
    initial begin
        rst_n = 1'b0; imem_rdata = 32'h0; imem_ready = 1'b0; advance = 1'b0;
        is_jump = 1'b0; zero_branch = 1'b0; need_zero = 1'b0; alu_zero = 1'b0;
        status_branch = 1'b0; need_st_Z = 1'b0; st_Z = 1'b0;
        pc_select = 2'b00; reg_target = 32'h0;
        step();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_pc", pc, 32'h0000_0000);
        check_eq("rst_instr", instruction, NOP);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("idle_to_fetch", {31'd0, imem_req}, 32'd1);

        // Sequential fetches 0,4,8,C then 0x10.
        for (int k = 0; k < 4; k++) begin
            do_fetch(32'(k) * 32'd4, 32'hA000_0000 | 32'(k));
            do_adv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        end
        do_fetch(32'h0000_0010, 32'h0);
        do_jump(32'h0000_0100);

        // Zero-branch taken backward: 0x104 - 8 = 0xFC.
        do_fetch(32'h0000_0100, 32'h1000_FFFE);
        do_adv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h0);
        do_fetch(32'h0000_00FC, 32'h0);
        do_jump(32'h0000_0100);
        // Zero-branch not taken.
        do_fetch(32'h0000_0100, 32'h1000_FFFE);
        do_adv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h0);
        do_fetch(32'h0000_0104, 32'h0);
        do_jump(32'h8000_0010);

        // Region jump, then again with a mismatching status branch.
        do_fetch(32'h8000_0010, 32'h0800_0040);
        do_adv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0);
        do_fetch(32'h8000_0100, 32'h0);
        do_jump(32'h8000_0010);
        do_fetch(32'h8000_0010, 32'h0800_0040);
        do_adv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h0);
        // Status branch taken forward: 0x8000_0104 + 12.
        do_fetch(32'h8000_0100, 32'h0000_0003);
        do_adv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h0);

        // Wait states with a stray advance.
        for (int w = 0; w < 3; w++) begin
            advance = 1'b1;
            check_eq("wait_req", {31'd0, imem_req}, 32'd1);
            check_eq("wait_valid", {31'd0, instr_valid}, 32'd0);
            check_eq("wait_nop", instruction, NOP);
            check_eq("wait_addr", imem_addr, 32'h8000_0110);
            step();
        end
        advance = 1'b0;
        do_fetch(32'h8000_0110, 32'h0);
        do_jump(32'hFFFF_FFFC);

        // Sequential wrap to zero.
        do_fetch(32'hFFFF_FFFC, 32'h0);
        do_adv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        do_fetch(32'h0000_0000, 32'h0);
        do_jump(32'h0000_0040);

        // Asynchronous reset in the middle of a fetch.
        check_eq("pre_rst_addr", imem_addr, 32'h0000_0040);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_req", {31'd0, imem_req}, 32'd0);
        check_eq("async_pc", pc, 32'h0000_0000);
        step();
        rst_n = 1'b1;
        step();
        do_fetch(32'h0000_0000, 32'h0);
        do_jump(32'h0000_0040);

        // Misaligned register target.
        do_fetch(32'h0000_0040, 32'h0);
        do_jump(32'h0000_0206);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int f = 0; f < 3; f++) begin
            check_eq("fault_flag", {31'd0, fault}, 32'd1);
            check_eq("fault_req", {31'd0, imem_req}, 32'd0);
            check_eq("fault_pc", pc, 32'h0000_0040);
            step();
        end
`else
        check_eq("nofault_flag", {31'd0, fault}, 32'd0);
        do_fetch(32'h0000_0204, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle control decoder.
- Holds the PC and runs a request/ready handshake with instruction memory.
- Presents a stable 32-bit instruction word to the decoder.
- Computes the next PC from the decoder's branch/jump outputs (is_jump, zero_branch/need_zero, status_branch/need_st_Z, pc_select) plus ALU-zero and status-Z flags.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word driven while no valid instruction is held.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_rdata  in  32  instruction word from memory, valid when imem_ready=1.
- imem_ready  in  1  memory response strobe, sampled only in FETCH.
- instruction  out  32  held instruction word to the control decoder.
- instr_valid  out  1  instruction holds a fetched word.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4, for link writes.
- advance  in  1  downstream finished executing the held instruction.
- is_jump  in  1  unconditional redirect.
- zero_branch  in  1  conditional branch on ALU zero.
- need_zero  in  1  required ALU-zero value for a taken branch.
- alu_zero  in  1  ALU zero flag for the held instruction.
- status_branch  in  1  conditional branch on status Z.
- need_st_Z  in  1  required status-Z value for a taken branch.
- st_Z  in  1  status-register Z flag.
- pc_select  in  2  target select: 00 pc+4, 01 branch, 10 jump, 11 register.
- reg_target  in  32  register-sourced target (JR/JALR/BR*).
- fault  out  1  misaligned-target fault (feature only; otherwise constant 0).

Behaviour:
- States: IDLE, FETCH, HOLD, FAULT (FAULT exists only with the optional feature).
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, instruction=NOP_WORD, instr_valid=0, imem_req=0, fault=0.
  - A reset asserted mid-fetch or mid-hold abandons the access immediately.
- IDLE: one cycle after reset release, unconditionally goes to FETCH.
- FETCH:
  - imem_req=1, instr_valid=0, instruction=NOP_WORD.
  - On an edge with imem_ready=1: instruction<=imem_rdata, instr_valid<=1, go HOLD.
  - Otherwise stay in FETCH; wait states are unbounded.
  - Minimum fetch latency is 1 cycle.
- HOLD:
  - imem_req=0; instruction and pc stay stable.
  - On an edge with advance=1: pc<=next_pc, instr_valid<=0, go FETCH.
  - Without advance, hold indefinitely.
  - advance is ignored in every state except HOLD.
- Taken condition, with priority is_jump > zero_branch > status_branch:
  - taken = is_jump | (zero_branch & (alu_zero==need_zero)) | (status_branch & (st_Z==need_st_Z)).
- next_pc:
  - If not taken, or pc_select=00: pc+4.
  - 01: pc+4 + (sext(instruction[15:0])<<2).
  - 10: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - 11: reg_target.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0, and backward branches wrap the same way.
- pc[1:0] is always 00. Handling of a target with nonzero low bits depends on the optional feature.
- imem_addr is combinational from pc.
- All outputs except imem_addr/pc_plus4 are registered or decoded from registered state.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - An advance whose next_pc[1:0]≠00 does not update pc; the unit enters FAULT instead.
  - In FAULT: fault=1, imem_req=0, instr_valid=0, pc holds the faulting instruction's address.
  - FAULT is left only by reset.
- Undefined:
  - next_pc[1:0] is forced to 00 and fetch continues.
  - There is no FAULT state, and fault is tied to 0.

Test Plan:
- Reset, then imem_ready=1 every cycle, advance pulsed in each HOLD with all branch inputs 0 -> imem_addr sequence 0,4,8,C; instruction follows imem_rdata; instr_valid high only in HOLD.
- pc=0x100, instruction=0x1000FFFE, zero_branch=1, need_zero=1, alu_zero=1, pc_select=01, advance -> next imem_addr=0x0FC. Same with alu_zero=0 -> 0x104.
- pc=0x8000_0010, instruction[25:0]=0x0000040, is_jump=1, pc_select=10 -> 0x8000_0100. Also assert status_branch=1 with a mismatching st_Z -> still 0x8000_0100 (is_jump priority).
- imem_ready held low 3 cycles in FETCH -> imem_req high 3+ cycles, instr_valid 0, instruction=NOP_WORD. advance pulsed during FETCH -> ignored, pc unchanged.
- pc=0xFFFF_FFFC, sequential advance -> imem_addr=0x0000_0000. Assert rst_n=0 mid-FETCH -> imem_req drops with no clock edge, pc=RESET_PC.
- is_jump=1, pc_select=11, reg_target=0x0000_0206 -> with macro: fault=1, pc stays at the faulting instruction, no further imem_req. Without macro: fetch from 0x0000_0204.
